div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
//   Multi-cycle controller and radix-2 restoring divider for RISC-V M-extension DIV/DIVU/REM/REMU.
//   Sits in the execute stage. Driven by div_en/div_ctrl from decode, carried down the ID/EX register.
//   Holds the front of the pipeline via stall_o until the quotient or remainder is ready.
// PARAMETERS
//   DATA_WIDTH  32  operand/result width; iteration count equals DATA_WIDTH
// PORTS
//   clk         in   1           rising-edge clock
//   rst_n       in   1           asynchronous reset, active-low
//   div_en_e    in   1           divide instruction present in execute
//   div_ctrl_e  in   2           00 DIV, 01 DIVU, 10 REM, 11 REMU
//   op_a_e      in   DATA_WIDTH  dividend (forwarded rs1)
//   op_b_e      in   DATA_WIDTH  divisor (forwarded rs2)
//   hold_e      in   1           external stall holding execute (e.g. load-use)
//   flush_e     in   1           execute flush (branch/jump mispredict)
//   stall_o     out  1           freeze fetch, decode and execute; bubble into memory stage
//   done_o      out  1           result_o valid this cycle
//   result_o    out  DATA_WIDTH  quotient or remainder per div_ctrl
// BEHAVIOUR
//   Reset: state=IDLE; stall_o=0, done_o=0, result_o=0; all internal registers cleared.
//     Reset is async and takes effect mid-operation; no done_o follows it.
//   FSM states: IDLE, BUSY, DONE.
//   IDLE -> BUSY when div_en_e=1 & flush_e=0 (accept edge T).
//     Latch the op, the signs and the operand magnitudes (abs applies to DIV/REM only).
//     Clear remainder; count=0.
//   BUSY, each cycle:
//     rem' = {rem[W-2:0], quo[W-1]} - |b|, and {quo[W-2:0], ~borrow}.
//     If borrow, restore rem (rem' = the shifted value).
//     count++. After DATA_WIDTH iterations (edges T+1..T+W) -> DONE.
//   Sign fix-up is applied while registering the result on the final iteration edge:
//     quotient is negated when signs differ (signed ops).
//     remainder takes the dividend's sign.
//   DONE: done_o=1 and result_o valid at cycle T+W+1; stall_o=0 so the pipeline advances.
//     hold_e=1: stay in DONE, result_o held, no restart.
//     hold_e=0: go to IDLE next edge.
//     A new div_en_e then starts a fresh op.
//   stall_o = div_en_e & ~flush_e & (state!=DONE); it is high during the IDLE accept cycle and all BUSY cycles.
//   Special cases, detected at accept:
//     divisor==0: quotient=all ones, remainder=op_a.
//     signed overflow (op_a=0x80..0, op_b=-1): quotient=0x80..0, remainder=0.
//     Override values replace the iterative result in DONE.
//   flush_e=1 in any state: go to IDLE next edge, no done_o, stall_o=0 in the flush cycle.
//     flush_e has priority over accept and hold_e.
//   result_o keeps its last value outside DONE; consumers qualify it with done_o.
//   div_ctrl_e/op changes during BUSY are ignored (the operation was latched at accept).
// CONFIGURATION
//   DIV_EARLY_OUT_EN defined: the special cases skip BUSY (IDLE -> DONE directly).
//     done_o arrives at T+1 with the override result.
//   DIV_EARLY_OUT_EN undefined: every op, special cases included, uses the fixed latency W+1.
// TESTING
//   DIVU 100/7 accepted at T -> stall_o=1 for T..T+32, done_o=1 at T+33, result_o=14; REMU same -> 2.
//   DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; REM 7/-2 -> 1.
//   DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
//     With DIV_EARLY_OUT_EN: done_o at T+1; without: done_o at T+33.
//   DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
//   flush_e pulsed at T+10 -> state IDLE at T+11, no done_o; a new DIVU 9/3 at T+12 returns 3 at T+45.
//   hold_e=1 for 3 cycles in DONE -> done_o/result_o stable 4 cycles, no re-accept.
//   rst_n low at T+5 -> all outputs 0 immediately.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer: execute-stage sequencer and radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip the iterations.
`timescale 1ns/1ps
module div_sequencer #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  div_en_e,
    input  logic [1:0]            div_ctrl_e,
    input  logic [DATA_WIDTH-1:0] op_a_e,
    input  logic [DATA_WIDTH-1:0] op_b_e,
    input  logic                  hold_e,
    input  logic                  flush_e,
    output logic                  stall_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] result_o
);
    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic             quo_neg_q, quo_neg_d;
    logic             rem_neg_q, rem_neg_d;
    logic [W-1:0]     rem_q, rem_d;
    logic [W-1:0]     quo_q, quo_d;
    logic [W-1:0]     dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovr_q, ovr_d;
    logic [W-1:0]     ovr_val_q, ovr_val_d;
    logic [W-1:0]     result_q, result_d;
    logic             done_q, done_d;

    logic             accept_c, is_signed_c, a_neg_c, b_neg_c, div_zero_c, sovf_c;
    logic [W-1:0]     a_abs_c, b_abs_c, ovr_res_c;
    logic [W:0]       shift_c;
    logic [W-1:0]     diff_c, rem_nx_c, quo_nx_c, quo_fix_c, rem_fix_c, fin_c;
    logic             borrow_c;

    // Operand decode at accept: magnitudes, signs and special-case results
    always_comb begin
        accept_c    = (state_q == S_IDLE) & div_en_e & ~flush_e;
        is_signed_c = ~div_ctrl_e[0];
        a_neg_c     = is_signed_c & op_a_e[W-1];
        b_neg_c     = is_signed_c & op_b_e[W-1];
        a_abs_c     = a_neg_c ? (~op_a_e + W'(1)) : op_a_e;
        b_abs_c     = b_neg_c ? (~op_b_e + W'(1)) : op_b_e;
        div_zero_c  = (op_b_e == '0);
        sovf_c      = is_signed_c & (op_a_e == {1'b1, {(W-1){1'b0}}}) & (op_b_e == '1);
        if (div_zero_c) begin
            ovr_res_c = div_ctrl_e[1] ? op_a_e : '1;
        end else begin
            // Overflow quotient equals the most-negative dividend itself
            ovr_res_c = div_ctrl_e[1] ? '0 : op_a_e;
        end
    end

    // One restoring step; the shifted partial remainder keeps its carry-out bit
    always_comb begin
        shift_c   = {rem_q, quo_q[W-1]};
        borrow_c  = (shift_c < {1'b0, dvs_q});
        diff_c    = shift_c[W-1:0] - dvs_q;
        rem_nx_c  = borrow_c ? shift_c[W-1:0] : diff_c;
        quo_nx_c  = {quo_q[W-2:0], ~borrow_c};
        quo_fix_c = quo_neg_q ? (~quo_nx_c + W'(1)) : quo_nx_c;
        rem_fix_c = rem_neg_q ? (~rem_nx_c + W'(1)) : rem_nx_c;
        if (ovr_q) begin
            fin_c = ovr_val_q;
        end else begin
            fin_c = ctrl_q[1] ? rem_fix_c : quo_fix_c;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        ovr_d     = ovr_q;
        ovr_val_d = ovr_val_q;
        result_d  = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    ctrl_d    = div_ctrl_e;
                    quo_neg_d = a_neg_c ^ b_neg_c;
                    rem_neg_d = a_neg_c;
                    rem_d     = '0;
                    quo_d     = a_abs_c;
                    dvs_d     = b_abs_c;
                    cnt_d     = '0;
                    ovr_d     = div_zero_c | sovf_c;
                    ovr_val_d = ovr_res_c;
`ifdef DIV_EARLY_OUT_EN
                    if (div_zero_c | sovf_c) begin
                        state_d  = S_DONE;
                        result_d = ovr_res_c;
                    end else begin
                        state_d = S_BUSY;
                    end
`else
                    state_d   = S_BUSY;
`endif
                end
            end
            S_BUSY: begin
                rem_d = rem_nx_c;
                quo_d = quo_nx_c;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(W - 1)) begin
                    state_d  = S_DONE;
                    result_d = fin_c;
                end
            end
            S_DONE: begin
                if (!hold_e) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_e) begin
            state_d = S_IDLE;
        end
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            ovr_q     <= 1'b0;
            ovr_val_q <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            ovr_q     <= ovr_d;
            ovr_val_q <= ovr_val_d;
            result_q  <= result_d;
            done_q    <= done_d;
        end
    end

    // Stall must rise in the accept cycle itself, so it follows div_en_e directly
    assign stall_o  = rst_n & div_en_e & ~flush_e & (state_q != S_DONE);
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed vector table plus flush, hold and reset sequences for div_sequencer.
`timescale 1ns/1ps
module tb_div_sequencer;
    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         div_en_e;
    logic [1:0]   div_ctrl_e;
    logic [W-1:0] op_a_e;
    logic [W-1:0] op_b_e;
    logic         hold_e;
    logic         flush_e;
    logic         stall_o;
    logic         done_o;
    logic [W-1:0] result_o;

    int n_chk  = 0;
    int n_fail = 0;

    div_sequencer #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .div_en_e   (div_en_e),
        .div_ctrl_e (div_ctrl_e),
        .op_a_e     (op_a_e),
        .op_b_e     (op_b_e),
        .hold_e     (hold_e),
        .flush_e    (flush_e),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .result_o   (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          special;
        string       name;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lat_for(input bit special);
`ifdef DIV_EARLY_OUT_EN
        return special ? 1 : 33;
`else
        return 33;
`endif
    endfunction

    // Issue one op, scramble inputs while busy, then check latency, result and hold behaviour
    task automatic run_op(input logic [1:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat, input int hold_cycles,
                          input string name);
        int n;
        bit seen;
        bit stall_bad;
        div_ctrl_e = ctrl;
        op_a_e     = a;
        op_b_e     = b;
        hold_e     = 1'b0;
        flush_e    = 1'b0;
        div_en_e   = 1'b1;
        #1;
        chk({name, " accept_stall"}, 32'(stall_o), 32'd1);
        n = 0;
        seen = 1'b0;
        stall_bad = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            op_a_e     = $urandom;
            op_b_e     = $urandom;
            div_ctrl_e = 2'($urandom);
            if (done_o) seen = 1'b1;
            else if (!stall_o) stall_bad = 1'b1;
        end
        chk({name, " busy_stall_drop"}, 32'(stall_bad), 32'd0);
        chk({name, " latency"}, 32'(n), 32'(lat));
        for (int k = 0; k <= hold_cycles; k++) begin
            chk({name, " done"}, 32'(done_o), 32'd1);
            chk({name, " result"}, result_o, exp);
            chk({name, " done_stall"}, 32'(stall_o), 32'd0);
            hold_e = (k < hold_cycles);
            if (k == hold_cycles) div_en_e = 1'b0;
            tick();
        end
        hold_e = 1'b0;
        chk({name, " done_clear"}, 32'(done_o), 32'd0);
    endtask

    initial begin
        vecs[0]  = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0, "divu_100_7"};
        vecs[1]  = '{2'b11, 32'd100,        32'd7,          32'd2,          1'b0, "remu_100_7"};
        vecs[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, "div_m7_2"};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  1'b0, "rem_m7_2"};
        vecs[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1,          1'b0, "rem_7_m2"};
        vecs[5]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, "div_5_0"};
        vecs[6]  = '{2'b11, 32'd5,          32'd0,          32'd5,          1'b1, "remu_5_0"};
        vecs[7]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b1, "div_ovf"};
        vecs[8]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b1, "rem_ovf"};
        vecs[9]  = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, "divu_max_1"};
        vecs[10] = '{2'b01, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1'b0, "divu_big"};
        vecs[11] = '{2'b11, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, "remu_big"};
        vecs[12] = '{2'b00, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         1'b0, "div_m100_m7"};
        vecs[13] = '{2'b10, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b0, "rem_m100_m7"};
        vecs[14] = '{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'd1,          1'b0, "remu_max_max1"};
        vecs[15] = '{2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1'b1, "rem_m5_0"};

        rst_n      = 1'b0;
        div_en_e   = 1'b1;
        div_ctrl_e = 2'b01;
        op_a_e     = 32'd100;
        op_b_e     = 32'd7;
        hold_e     = 1'b0;
        flush_e    = 1'b0;
        tick();
        tick();
        chk("reset_stall", 32'(stall_o), 32'd0);
        chk("reset_done", 32'(done_o), 32'd0);
        chk("reset_result", result_o, 32'd0);
        div_en_e = 1'b0;
        rst_n    = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].exp,
                   lat_for(vecs[i].special), 0, vecs[i].name);
        end

        // Flush ten cycles after accept, then a fresh DIVU 9/3
        div_ctrl_e = 2'b01;
        op_a_e     = 32'd1000;
        op_b_e     = 32'd3;
        div_en_e   = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        flush_e = 1'b1;
        #1;
        chk("flush_stall", 32'(stall_o), 32'd0);
        tick();
        flush_e  = 1'b0;
        div_en_e = 1'b0;
        #1;
        chk("flush_no_done", 32'(done_o), 32'd0);
        chk("flush_idle_stall", 32'(stall_o), 32'd0);
        tick();
        chk("flush_no_done2", 32'(done_o), 32'd0);
        run_op(2'b01, 32'd9, 32'd3, 32'd3, 33, 0, "divu_9_3_after_flush");

        // Hold in DONE for three cycles: four stable done cycles, no restart
        run_op(2'b01, 32'd100, 32'd7, 32'd14, 33, 3, "divu_hold");

        // Async reset in the middle of an op
        div_ctrl_e = 2'b01;
        op_a_e     = 32'd100;
        op_b_e     = 32'd7;
        div_en_e   = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_stall", 32'(stall_o), 32'd0);
        chk("midrst_done", 32'(done_o), 32'd0);
        chk("midrst_result", result_o, 32'd0);
        tick();
        div_en_e = 1'b0;
        rst_n    = 1'b1;
        begin
            bit done_seen;
            done_seen = 1'b0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (done_o) done_seen = 1'b1;
            end
            chk("midrst_no_done", 32'(done_seen), 32'd0);
        end
        run_op(2'b11, 32'd100, 32'd7, 32'd2, 33, 0, "remu_after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
